acc_cmd_arbiter: RTL
====================

Name: acc_cmd_arbiter

Overview:
- Shares the single serial `control` line of the 4-bit serial accumulator between NREQ requesters.
- Arbitrates round-robin once per 3-cycle frame and serialises the winner's 2-bit command (bit0 first, then bit1, then an execute slot).
- Keeps a shadow copy of ACC, so requesters can see the accumulator value without reading it.
- Sits between the requesters and the accumulator. Shares CLK and RST with the accumulator, so both frame counters stay phase-locked.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, grant-id width; must be at least clog2(NREQ).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- en  in  1  1 = schedule requests; 0 = issue only NOP frames.
- req  in  NREQ  per-requester request; held until granted.
- cmd  in  2*NREQ  requester i command at cmd[2i+1:2i]. Encoding: 01 = INC, 11 = LOAD8, 00 or 10 = NOP.
- gnt  out  NREQ  one-hot, one-cycle grant pulse.
- grant_id  out  IDW  index of the requester owning the current frame.
- busy  out  1  current frame carries a granted command.
- control  out  1  serial line to the accumulator's `control` input; registered.
- slot  out  2  frame phase: 0 = shift bit0, 1 = shift bit1, 2 = execute.
- acc_shadow  out  4  predicted accumulator value.
- zero_shadow  out  1  acc_shadow == 0.

Behaviour:
- Reset (RST low, asynchronous):
  - slot = 0, control = 0, gnt = 0, grant_id = 0, busy = 0.
  - Internal cmd_reg = 00, round-robin pointer = 0, acc_shadow = 0, zero_shadow = 1.
  - Reset during a frame aborts it with no shadow update. The accumulator resets on the same RST, so both restart at slot 0.
- Slot counter:
  - Sequence 0 -> 1 -> 2 -> 0, advancing on every edge after reset.
  - The accumulator samples `control` at the edge that ends slot 0 (bit0) and the edge that ends slot 1 (bit1). It executes at the edge that ends slot 2.
- First frame after reset:
  - control = 0 and cmd_reg = 00 throughout, so this frame is always NOP.
  - No request can be granted before the first slot-2 edge.
- Arbitration, at the edge ending slot 2 (entering slot 0):
  - If en = 1 and req != 0, the winner is the first asserted req at or after the pointer, searching upward with wrap.
  - On a win: gnt[winner] = 1 for exactly the following cycle; grant_id = winner; busy = 1; cmd_reg = winner's cmd; control = cmd[2*winner]; pointer = (winner+1) mod NREQ.
  - Otherwise: gnt = 0, busy = 0, cmd_reg = 00, control = 0; pointer and grant_id unchanged.
- Edge ending slot 0: control = cmd_reg[1].
- Edge ending slot 1: control = 0 (execute slot; value ignored by the accumulator).
- Requester handshake:
  - A requester samples gnt in the cycle after the grant edge. It may then drop req or present its next command; a new command competes at the next slot-2 edge.
  - The arbiter ignores req and cmd changes between grants. A command is captured only at the grant edge.
  - A granted NOP command still consumes its frame; busy = 1 for that frame.
- Shadow ACC, at the edge ending slot 2, using the cmd_reg of the frame just finishing:
  - 01: acc_shadow = acc_shadow + 1, 4-bit wrap (15 -> 0).
  - 11: acc_shadow = 8.
  - Otherwise: hold.
  - zero_shadow is combinational from acc_shadow.
  - Shadow update and next arbitration occur on the same edge with no interference.
- Enable: en sampled only at slot-2 edges. en = 0 holds pending requests; no grant and no request loss.
- Throughput: at most one command per 3 cycles.
- Latency: 3 cycles from grant edge to the edge where acc_shadow reflects the command.

Test Plan:
- Reset -> slot = 0, control = 0, gnt = 0, acc_shadow = 0, zero_shadow = 1. Free-run 6 cycles with req = 0 -> slot sequence 0,1,2,0,1,2; control stays 0; acc_shadow stays 0.
- req[1] = 1 with cmd = 01 -> gnt = 0010 for one cycle at a slot-0 start; control = 1 in slot 0, 0 in slot 1; after the slot-2 edge, acc_shadow = 1 and the accumulator ACC = 1, Zero = 0.
- req = 1111 held, all INC, pointer = 0 -> grants in order 0,1,2,3,0, one per frame. After 5 frames acc_shadow = 5, matching ACC.
- Requester 2 sends LOAD8 (11), then 8 INC frames -> acc_shadow = 8 after the first frame, then 9..15, then 0 with zero_shadow = 1; ACC tracks identically.
- en = 0 for 3 frames with req[0] = 1 -> no gnt, control = 0. Raise en -> grant at the next slot-2 edge.
- Assert RST low mid-frame (slot 1) while a LOAD8 is in flight -> immediate reset values; acc_shadow = 0; after release, slot restarts at 0 and ACC = acc_shadow.

Source files
------------

// File: rtl/acc_cmd_arbiter.sv
// Round-robin arbiter that time-shares the serial control line of a 4-bit accumulator.
// Each 3-cycle frame carries one 2-bit command (bit0, bit1, execute) and a shadow ACC tracks the result.
module acc_cmd_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] cmd,
    output logic [NREQ-1:0]   gnt,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic              control,
    output logic [1:0]        slot,
    output logic [3:0]        acc_shadow,
    output logic              zero_shadow
);

    typedef enum logic [1:0] {
        SLOT_BIT0 = 2'd0,
        SLOT_BIT1 = 2'd1,
        SLOT_EXEC = 2'd2
    } slot_e;

    slot_e             r_slot;
    slot_e             w_slot_nxt;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_grant_id;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_ctrl;
    logic [1:0]        r_cmd;
    logic [3:0]        r_acc;

    logic [2*NREQ-1:0] w_req_rot;
    logic              w_found;
    logic [IDW-1:0]    w_winner;
    logic [IDW-1:0]    w_ptr_nxt;
    logic [1:0]        w_win_cmd;
    logic [NREQ-1:0]   w_win_onehot;

    // Frame phase counter; it free-runs so it stays phase-locked with the accumulator.
    always_comb begin
        w_slot_nxt = SLOT_BIT0;
        case (r_slot)
            SLOT_BIT0: w_slot_nxt = SLOT_BIT1;
            SLOT_BIT1: w_slot_nxt = SLOT_EXEC;
            default:   w_slot_nxt = SLOT_BIT0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_slot <= SLOT_BIT0;
        else      r_slot <= w_slot_nxt;
    end

    // Rotate the request vector so bit 0 is the pointer position; the first set bit wins.
    assign w_req_rot = {req, req} >> r_ptr;

    always_comb begin
        int v_sum;
        w_found  = 1'b0;
        w_winner = '0;
        v_sum    = 0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                v_sum   = int'(r_ptr) + k;
                if (v_sum >= NREQ) v_sum = v_sum - NREQ;
                w_winner = IDW'(v_sum);
            end
        end
    end

    always_comb begin
        w_win_cmd    = 2'b00;
        w_win_onehot = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == IDW'(k)) begin
                w_win_cmd       = cmd[2*k +: 2];
                w_win_onehot[k] = 1'b1;
            end
        end
    end

    assign w_ptr_nxt = (w_winner == IDW'(NREQ - 1)) ? '0 : w_winner + IDW'(1);

    // Handshake: req[i] is a level held until gnt[i] pulses for one cycle at the start of a frame;
    // cmd is captured only on that grant edge, so req/cmd may change freely at any other time.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_ctrl     <= 1'b0;
            r_gnt      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_cmd      <= 2'b00;
            r_ptr      <= '0;
            r_acc      <= 4'd0;
        end else begin
            case (r_slot)
                SLOT_BIT0: begin
                    r_ctrl <= r_cmd[1];
                    r_gnt  <= '0;
                end
                SLOT_BIT1: begin
                    r_ctrl <= 1'b0;
                end
                default: begin
                    // Retire the finishing frame's command into the shadow, then arbitrate the next one.
                    if (r_cmd == 2'b01)      r_acc <= r_acc + 4'd1;
                    else if (r_cmd == 2'b11) r_acc <= 4'd8;
                    if (en && w_found) begin
                        r_gnt      <= w_win_onehot;
                        r_grant_id <= w_winner;
                        r_busy     <= 1'b1;
                        r_cmd      <= w_win_cmd;
                        r_ctrl     <= w_win_cmd[0];
                        r_ptr      <= w_ptr_nxt;
                    end else begin
                        r_gnt  <= '0;
                        r_busy <= 1'b0;
                        r_cmd  <= 2'b00;
                        r_ctrl <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign control     = r_ctrl;
    assign slot        = r_slot;
    assign acc_shadow  = r_acc;
    assign zero_shadow = (r_acc == 4'd0);

endmodule
